// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
//
// Shares one external combinational ALU between two requesters (typically the
// integer-execute pipe and the branch-compare/address unit). Requests are
// granted round-robin, registered into an EX stage that drives the ALU, and
// the ALU result is registered into a WB stage that returns it to the
// requester that issued it.
//
// Handshake semantics (both request and response sides):
//   A transfer happens on a rising clk edge when valid and ready are both high.
//   valid must not depend on ready. Once valid is raised, the payload stays
//   stable until the transfer. ready may depend on valid.
//
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   rX_valid / rX_ready    request handshake for requester X (0 or 1)
//   rX_a, rX_b, rX_op      request operands and ALU op
//   rX_rsp_valid / _ready  response handshake for requester X
//   rX_rsp_c               result (0 when rX_rsp_valid is low)
//   alu_a, alu_b, alu_op   drive to the external ALU
//   alu_c                  combinational ALU result
//   busy                   EX or WB holds a valid entry
// ---------------------------------------------------------------------------
module alu_share_arb #(
    parameter int               OP_W   = 5,
    parameter logic [OP_W-1:0]  NOP_OP = '0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [31:0]     r0_a,
    input  logic [31:0]     r0_b,
    input  logic [OP_W-1:0] r0_op,
    output logic            r0_rsp_valid,
    input  logic            r0_rsp_ready,
    output logic [31:0]     r0_rsp_c,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [31:0]     r1_a,
    input  logic [31:0]     r1_b,
    input  logic [OP_W-1:0] r1_op,
    output logic            r1_rsp_valid,
    input  logic            r1_rsp_ready,
    output logic [31:0]     r1_rsp_c,

    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [31:0]     alu_c,

    output logic            busy
);

    // EX stage
    logic            ex_valid;
    logic [31:0]     ex_a;
    logic [31:0]     ex_b;
    logic [OP_W-1:0] ex_op;
    logic            ex_own;

    // WB stage
    logic            wb_valid;
    logic [31:0]     wb_c;
    logic            wb_own;

    // Requester granted most recently; a tie goes to the other one.
    logic            last;

    logic            wb_free;
    logic            ex_adv;
    logic            ex_free;
    logic            grant0;
    logic            grant1;

    // WB can take a new entry when empty or when its owner consumes this cycle.
    always_comb begin
        wb_free = !wb_valid || (wb_own ? r1_rsp_ready : r0_rsp_ready);
        ex_adv  = ex_valid && wb_free;
        ex_free = !ex_valid || ex_adv;
    end

    // Round-robin grant: a lone requester always wins; on a tie the
    // requester that was not granted last wins.
    always_comb begin
        grant0 = ex_free && r0_valid && (!r1_valid || last);
        grant1 = ex_free && r1_valid && (!r0_valid || !last);
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // EX stage and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_op    <= NOP_OP;
            ex_own   <= 1'b0;
            last     <= 1'b1;
        end else begin
            if (grant0 || grant1) begin
                ex_valid <= 1'b1;
                ex_a     <= grant1 ? r1_a  : r0_a;
                ex_b     <= grant1 ? r1_b  : r0_b;
                ex_op    <= grant1 ? r1_op : r0_op;
                ex_own   <= grant1;
                last     <= grant1;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // WB stage: captures the ALU result when EX advances. Without an advance
    // a consumed entry simply empties; a stalled entry holds wb_c untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_c     <= '0;
            wb_own   <= 1'b0;
        end else begin
            if (ex_adv) begin
                wb_valid <= 1'b1;
                wb_c     <= alu_c;
                wb_own   <= ex_own;
            end else if (wb_valid && wb_free) begin
                wb_valid <= 1'b0;
            end
        end
    end

    // ALU drive: quiet operands and NOP when EX is empty.
    assign alu_a  = ex_valid ? ex_a  : '0;
    assign alu_b  = ex_valid ? ex_b  : '0;
    assign alu_op = ex_valid ? ex_op : NOP_OP;

    // Responses: only the owner of the WB entry ever sees it.
    assign r0_rsp_valid = wb_valid && !wb_own;
    assign r1_rsp_valid = wb_valid &&  wb_own;
    assign r0_rsp_c     = r0_rsp_valid ? wb_c : '0;
    assign r1_rsp_c     = r1_rsp_valid ? wb_c : '0;

    assign busy = ex_valid || wb_valid;

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
//
// Directed bench for alu_share_arb. A small ALU model closes the loop on the
// alu_* ports. The stimulus process pushes the hand-computed result of every
// accepted request (tagged with its owner) onto exp_q; an independent monitor
// pops and compares whenever a response handshake occurs.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

    localparam int OP_W = 5;
    localparam logic [OP_W-1:0] OP_NOP = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB = 5'd2;
    localparam logic [OP_W-1:0] OP_SLT = 5'd3;

    logic            clk;
    logic            rst;
    logic            r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [31:0]     r0_a, r0_b, r0_rsp_c;
    logic [OP_W-1:0] r0_op;
    logic            r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [31:0]     r1_a, r1_b, r1_rsp_c;
    logic [OP_W-1:0] r1_op;
    logic [31:0]     alu_a, alu_b, alu_c;
    logic [OP_W-1:0] alu_op;
    logic            busy;

    // Hand-computed expected result for the request currently presented.
    logic [31:0]     r0_exp, r1_exp;

    // Scoreboard: {owner, result}
    logic [32:0]     exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;

    alu_share_arb #(.OP_W(OP_W), .NOP_OP(OP_NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0_valid     (r0_valid),
        .r0_ready     (r0_ready),
        .r0_a         (r0_a),
        .r0_b         (r0_b),
        .r0_op        (r0_op),
        .r0_rsp_valid (r0_rsp_valid),
        .r0_rsp_ready (r0_rsp_ready),
        .r0_rsp_c     (r0_rsp_c),
        .r1_valid     (r1_valid),
        .r1_ready     (r1_ready),
        .r1_a         (r1_a),
        .r1_b         (r1_b),
        .r1_op        (r1_op),
        .r1_rsp_valid (r1_rsp_valid),
        .r1_rsp_ready (r1_rsp_ready),
        .r1_rsp_c     (r1_rsp_c),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_c        (alu_c),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external ALU model ----------------
    always_comb begin
        alu_c = 32'd0;
        case (alu_op)
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_SUB:  alu_c = alu_a - alu_b;
            OP_SLT:  alu_c = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_c = 32'd0;
        endcase
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic pop_cmp(input logic own, input logic [31:0] c);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got owner %0d value %0h expected no response at %0t",
                     own, c, $time);
        end else begin
            e = exp_q.pop_front();
            chk_b("rsp_owner", own, e[32]);
            chk("rsp_value", c, e[31:0]);
        end
    endtask

    always @(negedge clk) begin
        chk_b("single_owner", r0_rsp_valid && r1_rsp_valid, 1'b0);
        if (r0_rsp_valid && r0_rsp_ready) pop_cmp(1'b0, r0_rsp_c);
        else if (!r0_rsp_valid) chk("r0_rsp_c_idle", r0_rsp_c, 32'd0);
        if (r1_rsp_valid && r1_rsp_ready) pop_cmp(1'b1, r1_rsp_c);
        else if (!r1_rsp_valid) chk("r1_rsp_c_idle", r1_rsp_c, 32'd0);
    end

    // ---------------- driver tasks ----------------
    // One request cycle: checks the expected grants mid-cycle, records
    // accepted requests, then steps to just after the next rising edge.
    task automatic tick(input logic e0, input logic e1);
        @(negedge clk);
        chk_b("r0_ready", r0_ready, e0);
        chk_b("r1_ready", r1_ready, e1);
        if (r0_valid && r0_ready) exp_q.push_back({1'b0, r0_exp});
        if (r1_valid && r1_ready) exp_q.push_back({1'b1, r1_exp});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = OP_NOP; r0_rsp_ready = 1'b1; r0_exp = '0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = OP_NOP; r1_rsp_ready = 1'b1; r1_exp = '0;

        // Reset state and idle ALU drive
        #2;
        chk_b("rst_busy", busy, 1'b0);
        chk("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
        do_reset();
        @(negedge clk);
        chk("idle_alu_op", 32'(alu_op), 32'(OP_NOP));
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk_b("idle_busy", busy, 1'b0);
        chk_b("idle_r0_ready", r0_ready, 1'b0);
        chk_b("idle_r1_ready", r1_ready, 1'b0);
        @(posedge clk);
        #1;

        // Single op: 3+4 -> 7, two cycles from handshake to rsp_valid
        r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd3; r0_b = 32'd4; r0_exp = 32'd7;
        tick(1'b1, 1'b0);
        r0_valid = 1'b0;
        @(negedge clk);
        chk_b("single_ex_rsp_valid", r0_rsp_valid, 1'b0);
        chk_b("single_ex_busy", busy, 1'b1);
        chk("single_ex_alu_a", alu_a, 32'd3);
        chk("single_ex_alu_op", 32'(alu_op), 32'(OP_ADD));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_b("single_wb_rsp_valid", r0_rsp_valid, 1'b1);
        chk("single_wb_rsp_c", r0_rsp_c, 32'd7);
        chk_b("single_wb_r1_rsp_valid", r1_rsp_valid, 1'b0);
        chk("single_wb_alu_op", 32'(alu_op), 32'(OP_NOP));
        @(posedge clk);
        #1;
        drain();

        // Tie and round-robin from a fresh pointer
        do_reset();
        r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd1; r0_b = 32'd1; r0_exp = 32'd2;
        r1_valid = 1'b1; r1_op = OP_SUB; r1_a = 32'd5; r1_b = 32'd2; r1_exp = 32'd3;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        drain();

        // Backpressure on r0: two accepts, then stall with wb_c held
        r0_rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd10; r0_b = 32'd1; r0_exp = 32'd11;
        tick(1'b1, 1'b0);
        r0_a = 32'd20; r0_b = 32'd2; r0_exp = 32'd22;
        tick(1'b1, 1'b0);
        r0_a = 32'd30; r0_b = 32'd3; r0_exp = 32'd33;
        repeat (3) begin
            @(negedge clk);
            chk_b("bp_r0_ready", r0_ready, 1'b0);
            chk_b("bp_rsp_valid", r0_rsp_valid, 1'b1);
            chk("bp_rsp_c_held", r0_rsp_c, 32'd11);
            chk("bp_alu_a_held", alu_a, 32'd20);
            @(posedge clk);
            #1;
        end
        r0_rsp_ready = 1'b1;
        tick(1'b1, 1'b0);
        drain();

        // Reset mid-flight: fill WB and EX behind a stalled r1
        r1_rsp_ready = 1'b0;
        r1_valid = 1'b1; r1_op = OP_SUB; r1_a = 32'd9; r1_b = 32'd4; r1_exp = 32'd5;
        tick(1'b0, 1'b1);
        r1_a = 32'd8; r1_b = 32'd1; r1_exp = 32'd7;
        tick(1'b0, 1'b1);
        r1_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_b("arst_busy", busy, 1'b0);
        chk_b("arst_r0_rsp_valid", r0_rsp_valid, 1'b0);
        chk_b("arst_r1_rsp_valid", r1_rsp_valid, 1'b0);
        chk("arst_alu_op", 32'(alu_op), 32'(OP_NOP));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        r1_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd100; r0_b = 32'd23; r0_exp = 32'd123;
        r1_valid = 1'b1; r1_op = OP_SUB; r1_a = 32'd7;   r1_b = 32'd7;  r1_exp = 32'd0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        drain();

        // Lone requester r1: 8 back-to-back SLT(-1, 0) -> 1
        r1_valid = 1'b1; r1_op = OP_SLT; r1_a = 32'hFFFF_FFFF; r1_b = 32'd0; r1_exp = 32'd1;
        repeat (8) tick(1'b0, 1'b1);
        // Pointer left at r1, so the next tie goes to r0
        r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 32'd2; r0_b = 32'd2; r0_exp = 32'd4;
        tick(1'b1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
